// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// synchronous flush and sticky overflow/underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_req,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd_req,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              rd_ok;

    // Status comes only from the registered pointers, so requests never reach the flags combinationally.
    always_comb begin
        count        = wr_ptr - rd_ptr;
        fifo_full    = (count == DEPTH_C);
        fifo_empty   = (count == '0);
        almost_full  = (count >= AF_C);
        almost_empty = (count <= AE_C);
        wr_ok        = wr_req && !fifo_full && !clr && !rst;
        rd_ok        = rd_req && !fifo_empty && !clr && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_req && fifo_full)
                overflow <= 1'b1;
            if (rd_req && fifo_empty)
                underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    always_comb begin
        data_out   = mem[rd_ptr[ADDR_W-1:0]];
        data_valid = !fifo_empty;
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            if (rd_ok)
                data_out <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=12, AE=4); builds with or without SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] data_in = '0;
    logic       rd_req = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AF_THRESH(12),
        .AE_THRESH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .wr_req      (wr_req),
        .data_in     (data_in),
        .rd_req      (rd_req),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    typedef struct {
        bit         r;
        bit         c;
        bit         w;
        bit         rd;
        logic [7:0] din;
        int         cnt;
        bit         ovf;
        bit         unf;
    } vec_t;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input bit r, input bit c, input bit w, input logic [7:0] d, input bit rd);
        rst     = r;
        clr     = c;
        wr_req  = w;
        data_in = d;
        rd_req  = rd;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        clr    = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    // Flags are {full, empty, almost_full, almost_empty, overflow, underflow}.
    task automatic chk_status(input string name, input int cnt, input bit ovf, input bit unf);
        logic [5:0] exp_f;
        exp_f = {cnt == 16, cnt == 0, cnt >= 12, cnt <= 4, ovf, unf};
        chk({name, "_count"}, count, cnt);
        chk({name, "_flags"}, {fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow}, exp_f);
    endtask

    task automatic pop(input string name, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        chk({name, "_valid"}, data_valid, 1);
        chk({name, "_data"}, data_out, exp);
        step(0, 0, 0, 8'h00, 1);
`else
        step(0, 0, 0, 8'h00, 1);
        chk({name, "_valid"}, data_valid, 1);
        chk({name, "_data"}, data_out, exp);
`endif
    endtask

    initial begin
        vec_t       vt[$];
        vec_t       v;
        logic [7:0] q[$];
        logic [7:0] popped;
        bit         w, r, w_ok, r_ok;
        logic [7:0] d;
        int         exp_dv;

        // Reset, fill 16 words, then one rejected write while full.
        vt.push_back('{r:1, c:0, w:0, rd:0, din:8'h00, cnt:0, ovf:0, unf:0});
        vt.push_back('{r:1, c:0, w:1, rd:1, din:8'h77, cnt:0, ovf:0, unf:0});
        for (int k = 1; k <= 16; k++)
            vt.push_back('{r:0, c:0, w:1, rd:0, din:8'(k), cnt:k, ovf:0, unf:0});
        vt.push_back('{r:0, c:0, w:1, rd:0, din:8'hAA, cnt:16, ovf:1, unf:0});

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            step(v.r, v.c, v.w, v.din, v.rd);
            chk_status($sformatf("vec%0d", i), v.cnt, v.ovf, v.unf);
`ifdef SYNC_FIFO_FWFT_EN
            exp_dv = (v.cnt != 0) ? 1 : 0;
`else
            exp_dv = 0;
            if (v.r)
                chk($sformatf("vec%0d_rst_data", i), data_out, 0);
`endif
            chk($sformatf("vec%0d_valid", i), data_valid, exp_dv);
        end

        // Drain in order; 0xAA must never appear.
        for (int j = 1; j <= 16; j++) begin
            pop($sformatf("drain%0d", j), 8'(j));
            chk_status($sformatf("drain%0d", j), 16 - j, 1, 0);
        end
        step(0, 0, 0, 8'h00, 1);
        chk_status("extra_rd", 0, 1, 1);
        chk("extra_rd_valid", data_valid, 0);

        // Wrap-around traffic against a queue model: fill-biased, then drain-biased.
        for (int c = 0; c < 40; c++) begin
            if (c < 20) begin
                w = 1'b1;
                r = ($urandom_range(0, 4) == 0);
            end else begin
                w = ($urandom_range(0, 4) == 0);
                r = 1'b1;
            end
            d = 8'($urandom);
            w_ok = w && (q.size() < 16);
            r_ok = r && (q.size() > 0);
`ifdef SYNC_FIFO_FWFT_EN
            if (q.size() > 0)
                chk($sformatf("wrap%0d_head", c), data_out, q[0]);
`endif
            popped = 8'h00;
            if (r_ok)
                popped = q.pop_front();
            if (w_ok)
                q.push_back(d);
            step(0, 0, w, d, r);
            chk($sformatf("wrap%0d_count", c), count, q.size());
`ifdef SYNC_FIFO_FWFT_EN
            chk($sformatf("wrap%0d_valid", c), data_valid, (q.size() > 0) ? 1 : 0);
`else
            chk($sformatf("wrap%0d_valid", c), data_valid, r_ok ? 1 : 0);
            if (r_ok)
                chk($sformatf("wrap%0d_data", c), data_out, popped);
`endif
        end

        // Full with simultaneous read+write: read wins, write rejected.
        step(1, 0, 0, 8'h00, 0);
        chk_status("rst2", 0, 0, 0);
        for (int i = 0; i < 16; i++)
            step(0, 0, 1, 8'(8'h20 + i), 0);
        chk_status("full2", 16, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("full_rw_head", data_out, 8'h20);
        step(0, 0, 1, 8'hBB, 1);
`else
        step(0, 0, 1, 8'hBB, 1);
        chk("full_rw_data", data_out, 8'h20);
`endif
        chk_status("full_rw", 15, 1, 0);
        for (int i = 1; i < 16; i++)
            pop($sformatf("drain2_%0d", i), 8'(8'h20 + i));
        chk_status("drain2", 0, 1, 0);

        // Empty with simultaneous read+write: write wins, read rejected.
        step(0, 0, 1, 8'hC3, 1);
        chk_status("empty_rw", 1, 1, 1);
`ifdef SYNC_FIFO_FWFT_EN
        chk("empty_rw_valid", data_valid, 1);
`else
        chk("empty_rw_valid", data_valid, 0);
`endif
        pop("empty_rw_pop", 8'hC3);
        chk_status("empty_rw_done", 0, 1, 1);

        // Flush with a concurrent write: write dropped, sticky errors kept.
        for (int i = 0; i < 7; i++)
            step(0, 0, 1, 8'(8'h60 + i), 0);
        chk_status("pre_clr", 7, 1, 1);
        step(0, 1, 1, 8'h99, 0);
        chk_status("clr", 0, 1, 1);
        chk("clr_valid", data_valid, 0);
        step(0, 0, 1, 8'h55, 0);
        chk_status("post_clr_wr", 1, 1, 1);
        pop("post_clr_pop", 8'h55);
        chk_status("post_clr_done", 0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
